// File: rtl/iob_bus_arbiter.sv
// -----------------------------------------------------------------------------
// iob_bus_arbiter
//
// Merges two IOb native requesters onto a single IOb memory port. Port 0 is
// the CPU data bus and port 1 is the CPU instruction bus. Only one transaction
// is outstanding at a time. Reads return their data to the port that issued
// them.
//
// Parameters
//   ADDR_W   address width of all ports
//   DATA_W   data width; strobe width is DATA_W/8
//   RR       1 = round-robin between the ports, 0 = port 0 always wins
//
// Ports
//   clk_i, rst_i, cke_i             clock, sync active-high reset, clock enable
//   m0_* / m1_*                     requester ports (avalid/addr/wdata/wstrb in,
//                                   rdata/rvalid/ready out)
//   s_*                             shared memory port (avalid/addr/wdata/wstrb
//                                   out, rdata/rvalid/ready in)
// -----------------------------------------------------------------------------
module iob_bus_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int RR     = 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                cke_i,

    input  logic                m0_avalid_i,
    input  logic [ADDR_W-1:0]   m0_addr_i,
    input  logic [DATA_W-1:0]   m0_wdata_i,
    input  logic [DATA_W/8-1:0] m0_wstrb_i,
    output logic [DATA_W-1:0]   m0_rdata_o,
    output logic                m0_rvalid_o,
    output logic                m0_ready_o,

    input  logic                m1_avalid_i,
    input  logic [ADDR_W-1:0]   m1_addr_i,
    input  logic [DATA_W-1:0]   m1_wdata_i,
    input  logic [DATA_W/8-1:0] m1_wstrb_i,
    output logic [DATA_W-1:0]   m1_rdata_o,
    output logic                m1_rvalid_o,
    output logic                m1_ready_o,

    output logic                s_avalid_o,
    output logic [ADDR_W-1:0]   s_addr_o,
    output logic [DATA_W-1:0]   s_wdata_o,
    output logic [DATA_W/8-1:0] s_wstrb_o,
    input  logic [DATA_W-1:0]   s_rdata_i,
    input  logic                s_rvalid_i,
    input  logic                s_ready_i
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        WAIT_R = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   owner_q, owner_d;
    logic   rrPtr_q, rrPtr_d;

    logic   sel;
    logic   selValid;
    logic   accept;
    logic   isRead;

    // State register. Reset wins over the clock enable so that an abandoned
    // transaction is always cleared; otherwise everything holds while cke_i is
    // low. rrPtr_q names the port that wins the next tie.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            rrPtr_q <= 1'b0;
        end else if (cke_i) begin
            state_q <= state_d;
            owner_q <= owner_d;
            rrPtr_q <= rrPtr_d;
        end
    end

    // Next-state logic. The owner is latched whenever a request is forwarded
    // from IDLE, so HOLD and WAIT_R keep serving the same port. The tie-break
    // pointer moves to the other port only when a request is actually accepted,
    // so a stalled request never loses its turn.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        rrPtr_d = rrPtr_q;
        case (state_q)
            IDLE: begin
                if (s_avalid_o) begin
                    owner_d = sel;
                    if (accept) begin
                        rrPtr_d = ~sel;
                        if (isRead) begin
                            state_d = WAIT_R;
                        end
                    end else begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (accept) begin
                    rrPtr_d = ~sel;
                    state_d = isRead ? WAIT_R : IDLE;
                end
            end
            WAIT_R: begin
                if (s_rvalid_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output logic. In IDLE the winner is picked combinationally and forwarded
    // with no added latency; outside IDLE the latched owner is forwarded so the
    // grant stays locked. With no request pending the mux rests on port 0.
    // Read data is broadcast, but rvalid only reaches the owner and only while
    // a read is actually outstanding, so stray or late rvalids are dropped.
    always_comb begin
        sel = 1'b0;
        if (state_q == IDLE) begin
            if (m0_avalid_i && m1_avalid_i) begin
                sel = (RR != 0) ? rrPtr_q : 1'b0;
            end else if (m1_avalid_i) begin
                sel = 1'b1;
            end
        end else begin
            sel = owner_q;
        end

        selValid    = sel ? m1_avalid_i : m0_avalid_i;
        s_addr_o    = sel ? m1_addr_i   : m0_addr_i;
        s_wdata_o   = sel ? m1_wdata_i  : m0_wdata_i;
        s_wstrb_o   = sel ? m1_wstrb_i  : m0_wstrb_i;
        s_avalid_o  = (state_q != WAIT_R) && selValid;

        accept      = s_avalid_o && s_ready_i;
        isRead      = (s_wstrb_o == '0);

        m0_ready_o  = accept && !sel;
        m1_ready_o  = accept && sel;

        m0_rdata_o  = s_rdata_i;
        m1_rdata_o  = s_rdata_i;
        m0_rvalid_o = (state_q == WAIT_R) && !owner_q && s_rvalid_i;
        m1_rvalid_o = (state_q == WAIT_R) && owner_q && s_rvalid_i;
    end

endmodule

// File: doc/iob_bus_arbiter.md
Name: iob_bus_arbiter

Overview:
- Two-requester arbiter that merges the CPU instruction bus and data bus onto one IOb native memory port.
- Used where a single-ported memory or interconnect serves both buses, e.g. a shared SRAM or an external-memory bridge.
- Supports at most one outstanding transaction at a time.
- Offers fixed-priority or round-robin arbitration, locks the grant until the request is accepted, and routes the read response back to the owning requester.

Parameters:
- ADDR_W, 32, address width of all ports.
- DATA_W, 32, data width; wstrb width is DATA_W/8.
- RR, 1, 1 = round-robin arbitration; 0 = fixed priority with port 0 (data) always winning.

Ports:
- clk_i  input  1  system clock.
- rst_i  input  1  synchronous active-high reset.
- cke_i  input  1  clock enable; all registers hold when 0.
- m0_avalid_i  input  1  port 0 (data bus) request valid.
- m0_addr_i  input  ADDR_W  port 0 address.
- m0_wdata_i  input  DATA_W  port 0 write data.
- m0_wstrb_i  input  DATA_W/8  port 0 byte strobes; all zero = read.
- m0_rdata_o  output  DATA_W  port 0 read data.
- m0_rvalid_o  output  1  port 0 read data valid.
- m0_ready_o  output  1  port 0 request accepted.
- m1_avalid_i, m1_addr_i, m1_wdata_i, m1_wstrb_i, m1_rdata_o, m1_rvalid_o, m1_ready_o: port 1 (instruction bus), same widths and meanings as port 0.
- s_avalid_o  output  1  shared-port request valid.
- s_addr_o  output  ADDR_W  shared-port address.
- s_wdata_o  output  DATA_W  shared-port write data.
- s_wstrb_o  output  DATA_W/8  shared-port byte strobes.
- s_rdata_i  input  DATA_W  shared-port read data.
- s_rvalid_i  input  1  shared-port read data valid.
- s_ready_i  input  1  shared-port request accepted.

Behaviour:
- Handshake rules:
  - A request is accepted in the cycle where avalid=1 and ready=1.
  - A requester holds avalid, addr, wdata and wstrb stable until accepted.
  - Writes complete on acceptance.
  - Reads complete when s_rvalid_i=1, one or more cycles after acceptance.
- State machine has three states: IDLE, HOLD, WAIT_R.
- Reset values (rst_i=1 at a clk_i edge, regardless of cke_i):
  - State = IDLE; owner = port 0; round-robin pointer = port 0 preferred.
  - All ready/rvalid outputs are 0 and s_avalid_o=0 combinationally while in IDLE with no avalid.
  - A reset during HOLD or WAIT_R abandons the transaction; a late s_rvalid_i after reset is ignored (state IDLE, rvalid outputs stay 0).
- IDLE:
  - Winner is chosen combinationally among asserted avalids.
  - RR=0: port 0 wins ties.
  - RR=1: the port not granted last wins ties. The pointer updates only on acceptance.
  - Winner's request is forwarded to s_* in the same cycle (zero added latency). s_ready_i is routed to the winner's ready; the loser's ready stays 0.
  - Accepted with wstrb≠0: stay IDLE.
  - Accepted with wstrb=0: latch owner, go to WAIT_R.
  - Not accepted (s_ready_i=0): latch owner, go to HOLD.
- HOLD:
  - Forward only the latched owner's request; arbitration is frozen even if the other port asserts.
  - On acceptance: write → IDLE; read → WAIT_R.
- WAIT_R:
  - s_avalid_o=0 and both ready outputs are 0.
  - s_rdata_i is broadcast to both rdata outputs; s_rvalid_i is gated to the owner's rvalid only.
  - On s_rvalid_i=1, return to IDLE. A new grant is possible from the next cycle, giving a one-cycle bubble between read completion and next acceptance.
- When no avalid is asserted, s_avalid_o=0 and s_addr/wdata/wstrb follow port 0 (don't-care).
- s_rvalid_i in IDLE or HOLD (protocol violation) is not forwarded to either port.
- With cke_i=0, state and pointer hold; combinational forwarding continues.

Test Plan:
- Single read on port 1, addr 0x100, s_ready_i=1 immediately, s_rvalid_i 2 cycles later with 0xDEADBEEF → m1_ready_o pulses 1 cycle; m1_rvalid_o=1 with m1_rdata_o=0xDEADBEEF; m0_rvalid_o stays 0.
- Simultaneous reads on both ports, RR=1, four back-to-back rounds, slave always ready with rvalid after 1 cycle → grants alternate 0,1,0,1. With RR=0, port 0 wins every contested round.
- Port 0 write, wstrb=0xF, addr 0x20, data 0x12345678, s_ready_i low 3 cycles, port 1 asserts during the stall → s_* holds port 0 values all 4 cycles; port 1 is granted only after port 0's acceptance.
- Read accepted, then rst_i asserted in WAIT_R, then s_rvalid_i arrives → no rvalid on either port; state IDLE; next port 1 request is granted immediately.
- cke_i=0 for 5 cycles during HOLD with s_ready_i=0 → owner unchanged. Raising cke_i with s_ready_i=1 completes the original owner's transaction.
